// File: rtl/hex_scan_driver_pkg.sv
// Shared types and constants for the multiplexed hex display driver.
package SLC3_TYPES;

  // Scan phases: a digit is lit during SCAN_ON, everything is dark during SCAN_GAP.
  typedef enum logic {
    SCAN_ON  = 1'b0,
    SCAN_GAP = 1'b1
  } scan_state_e;

  // One complete display image: four nibbles plus per-digit blank/dp and lz enable.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic        lz;
  } disp_img_t;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0123456789AbCdEF; entry n is glyph n.
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_seg_decode
  import SLC3_TYPES::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Table lookup into the shared glyph constant.
  always_comb begin
    o_seg = HEX_GLYPHS[i_nibble];
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed four-digit hex display driver with blanking gaps and a
// double-buffered image that only updates on frame boundaries.
module hex_scan_driver
  import SLC3_TYPES::*;
#(
  parameter int unsigned ON_CYCLES  = 50000,
  parameter int unsigned GAP_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_i,
  input  logic [3:0]  blank_i,
  input  logic [3:0]  dp_i,
  input  logic        lz_i,
  input  logic        load_i,
  output logic [7:0]  hex_seg_o,
  output logic [3:0]  hex_grid_o,
  output logic        pending_o
);

  localparam int unsigned MaxCycles = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  // A single-cycle maximum would give a zero-width counter; keep at least one bit.
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] OnLast  = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);

  scan_state_e     r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [1:0]      r_idx, w_idx_next;
  logic            w_frame_copy;

  disp_img_t       r_shadow, r_disp;
  disp_img_t       w_new_img;
  logic            r_pending;

  logic [3:0]      w_nibble;
  logic [6:0]      w_glyph;
  logic [15:0]     w_upper;
  logic            w_lz_blank;
  logic [7:0]      w_seg;
  logic [3:0]      w_grid;
  logic [7:0]      r_seg;
  logic [3:0]      r_grid;

  assign w_new_img = '{data: data_i, blank: blank_i, dp: dp_i, lz: lz_i};

  // Scan state, tick counter and digit index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SCAN_GAP;
      r_cnt   <= '0;
      r_idx   <= 2'd3;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next-state logic: ON phase then GAP phase per digit; leaving the gap after
  // digit 3 is the frame boundary where the shadow image is taken.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CntW'(1);
    w_idx_next   = r_idx;
    w_frame_copy = 1'b0;
    unique case (r_state)
      SCAN_ON: begin
        if (r_cnt == OnLast) begin
          w_state_next = SCAN_GAP;
          w_cnt_next   = '0;
        end
      end
      SCAN_GAP: begin
        if (r_cnt == GapLast) begin
          w_state_next = SCAN_ON;
          w_cnt_next   = '0;
          w_idx_next   = r_idx + 2'd1;
          w_frame_copy = (r_idx == 2'd3);
        end
      end
      default: begin
        w_state_next = SCAN_GAP;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Shadow capture, frame-boundary copy and pending flag; a load landing on the
  // boundary still copies the old shadow and keeps the new value pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow  <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (load_i) begin
        r_shadow <= w_new_img;
      end
      if (w_frame_copy) begin
        r_disp <= r_shadow;
      end
      if (load_i) begin
        r_pending <= 1'b1;
      end else if (w_frame_copy) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign w_nibble = r_disp.data[{r_idx, 2'b00} +: 4];

  hex_seg_decode u_seg_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  // Leading-zero blanking: nibble n and all higher nibbles zero, never digit 0.
  always_comb begin
    w_upper    = r_disp.data >> {r_idx, 2'b00};
    w_lz_blank = r_disp.lz && (r_idx != 2'd0) && (w_upper == 16'h0000);
  end

  // Output selection for the current state and digit.
  always_comb begin
    w_grid = 4'hF;
    w_seg  = 8'hFF;
    if (r_state == SCAN_ON) begin
      w_grid = ~(4'b0001 << r_idx);
      if (!(r_disp.blank[r_idx] || w_lz_blank)) begin
        w_seg = {~r_disp.dp[r_idx], w_glyph};
      end
    end
  end

  // Registered outputs, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg  <= 8'hFF;
      r_grid <= 4'hF;
    end else begin
      r_seg  <= w_seg;
      r_grid <= w_grid;
    end
  end

  assign hex_seg_o  = r_seg;
  assign hex_grid_o = r_grid;
  assign pending_o  = r_pending;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver with ON_CYCLES=4, GAP_CYCLES=2.
module tb_hex_scan_driver;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic        lz;
  } img_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_i;
  logic [3:0]  blank_i;
  logic [3:0]  dp_i;
  logic        lz_i;
  logic        load_i;
  logic [7:0]  hex_seg_o;
  logic [3:0]  hex_grid_o;
  logic        pending_o;

  int checks = 0;
  int errors = 0;

  hex_scan_driver #(
    .ON_CYCLES  (4),
    .GAP_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_i     (data_i),
    .blank_i    (blank_i),
    .dp_i       (dp_i),
    .lz_i       (lz_i),
    .load_i     (load_i),
    .hex_seg_o  (hex_seg_o),
    .hex_grid_o (hex_grid_o),
    .pending_o  (pending_o)
  );

  always #5 clk = ~clk;

  // Standard active-low hex glyphs with the dp bit off.
  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [3:0] grid_of(input int unsigned d);
    logic [3:0] g;
    g = 4'hF;
    g[d[1:0]] = 1'b0;
    return g;
  endfunction

  function automatic logic [7:0] ref_seg(input img_t v, input int unsigned d);
    logic [1:0]  di;
    logic [15:0] upper;
    logic [7:0]  g;
    di    = d[1:0];
    upper = v.data >> (4 * d);
    if (v.blank[di] || (v.lz && di != 2'd0 && upper == 16'h0000)) return 8'hFF;
    g    = glyph(v.data[4*di +: 4]);
    g[7] = ~v.dp[di];
    return g;
  endfunction

  // Reference model: a frame is 24 cycles (4 digits x (4 on + 2 gap)); reset
  // leaves the scan 22 cycles into the frame (digit 3, gap start).
  img_t        m_shadow, m_disp;
  int unsigned m_k;
  int unsigned m_pos;
  logic [3:0]  exp_grid;
  logic [7:0]  exp_seg;
  logic        exp_pend;

  assign m_pos = (22 + m_k) % 24;

  always @(posedge clk) begin
    if (reset) begin
      m_k      <= 0;
      m_shadow <= '0;
      m_disp   <= '0;
      exp_pend <= 1'b0;
      exp_grid <= 4'hF;
      exp_seg  <= 8'hFF;
    end else begin
      if (m_pos % 6 < 4) begin
        exp_grid <= grid_of(m_pos / 6);
        exp_seg  <= ref_seg(m_disp, m_pos / 6);
      end else begin
        exp_grid <= 4'hF;
        exp_seg  <= 8'hFF;
      end
      if (m_pos == 23) m_disp <= m_shadow;
      if (load_i) m_shadow <= '{data: data_i, blank: blank_i, dp: dp_i, lz: lz_i};
      exp_pend <= load_i ? 1'b1 : ((m_pos == 23) ? 1'b0 : exp_pend);
      m_k      <= (m_k + 1) % 24;
    end
  end

  task automatic load_value(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p,
                            input logic z);
    data_i  = d;
    blank_i = b;
    dp_i    = p;
    lz_i    = z;
    load_i  = 1'b1;
  endtask

  // Leaves the bench at the falling edge just after one reset edge.
  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    load_i = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    load_value(16'hFFFF, 4'h0, 4'hF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (hex_grid_o !== 4'hF || hex_seg_o !== 8'hFF || pending_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold grid=%h seg=%h pend=%b required F FF 0",
                 hex_grid_o, hex_seg_o, pending_o);
      end
    end
    reset  = 1'b0;
    load_i = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      @(negedge clk);
      if (m == 3) begin
        checks++;
        if (hex_grid_o !== 4'hE || hex_seg_o !== 8'hC0 || pending_o !== 1'b0) begin
          errors++;
          $display("FAIL reset_first_digit grid=%h seg=%h pend=%b required E C0 0",
                   hex_grid_o, hex_seg_o, pending_o);
        end
      end
    end
  endtask

  // Four frames: zeros, 12AF loaded mid-frame, 0005 lz=1 loaded on the frame
  // boundary, then 0005 lz=0.
  task automatic test_frame_updates();
    logic [7:0]  img [4][4];
    logic [3:0]  eg;
    logic [7:0]  es;
    logic        ep;
    int unsigned f, p, d;
    img[0] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
    img[1] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    img[2] = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
    img[3] = '{8'h92, 8'hC0, 8'hC0, 8'hC0};
    do_reset();
    for (int m = 1; m <= 98; m++) begin
      @(negedge clk);
      eg = 4'hF;
      es = 8'hFF;
      if (m >= 3) begin
        f = (m - 3) / 24;
        p = (m - 3) % 24;
        d = p / 6;
        if (p % 6 < 4) begin
          eg = grid_of(d);
          es = img[f][d];
        end
      end
      ep = (m >= 11 && m <= 49) || (m >= 61 && m <= 73);
      checks++;
      if (hex_grid_o !== eg || hex_seg_o !== es || pending_o !== ep) begin
        errors++;
        $display("FAIL frame_updates m=%0d got grid=%h seg=%h pend=%b required grid=%h seg=%h pend=%b",
                 m, hex_grid_o, hex_seg_o, pending_o, eg, es, ep);
      end
      load_i = 1'b0;
      if (m == 10) load_value(16'h12AF, 4'h0, 4'h0, 1'b0);
      if (m == 25) load_value(16'h0005, 4'h0, 4'h0, 1'b1);
      if (m == 60) load_value(16'h0005, 4'h0, 4'h0, 1'b0);
    end
    load_i = 1'b0;
  endtask

  task automatic test_blank_dp();
    logic [7:0]  img [4];
    logic [3:0]  eg;
    logic [7:0]  es;
    int unsigned p, d;
    img = '{8'h00, 8'h80, 8'hFF, 8'h80};
    do_reset();
    load_value(16'h8888, 4'b0100, 4'b0001, 1'b0);
    for (int m = 1; m <= 26; m++) begin
      @(negedge clk);
      load_i = 1'b0;
      eg = 4'hF;
      es = 8'hFF;
      if (m >= 3) begin
        p = m - 3;
        d = p / 6;
        if (p % 6 < 4) begin
          eg = grid_of(d);
          es = img[d];
        end
      end
      checks++;
      if (hex_grid_o !== eg || hex_seg_o !== es || pending_o !== (m == 1)) begin
        errors++;
        $display("FAIL blank_dp m=%0d got grid=%h seg=%h pend=%b required grid=%h seg=%h pend=%b",
                 m, hex_grid_o, hex_seg_o, pending_o, eg, es, (m == 1));
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    load_value(16'hFFFF, 4'h0, 4'h0, 1'b0);
    for (int m = 1; m <= 16; m++) begin
      @(negedge clk);
      load_i = 1'b0;
      if (m >= 15) begin
        checks++;
        if (hex_grid_o !== 4'hB || hex_seg_o !== 8'h8E || pending_o !== 1'b0) begin
          errors++;
          $display("FAIL digit2_before_reset m=%0d grid=%h seg=%h pend=%b required B 8E 0",
                   m, hex_grid_o, hex_seg_o, pending_o);
        end
      end
    end
    reset = 1'b1;
    load_value(16'h1234, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (hex_grid_o !== 4'hF || hex_seg_o !== 8'hFF || pending_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_scan grid=%h seg=%h pend=%b required F FF 0",
               hex_grid_o, hex_seg_o, pending_o);
    end
    reset  = 1'b0;
    load_i = 1'b0;
    for (int m = 1; m <= 9; m++) begin
      @(negedge clk);
      if (m == 3 || m == 9) begin
        checks++;
        if (hex_grid_o !== grid_of((m - 3) / 6) || hex_seg_o !== 8'hC0 || pending_o !== 1'b0) begin
          errors++;
          $display("FAIL display_zeroed m=%0d grid=%h seg=%h pend=%b required %h C0 0",
                   m, hex_grid_o, hex_seg_o, pending_o, grid_of((m - 3) / 6));
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if (hex_grid_o !== exp_grid || hex_seg_o !== exp_seg || pending_o !== exp_pend) begin
        errors++;
        $display("FAIL random i=%0d got grid=%h seg=%h pend=%b required grid=%h seg=%h pend=%b",
                 i, hex_grid_o, hex_seg_o, pending_o, exp_grid, exp_seg, exp_pend);
      end
      reset   = ($urandom_range(0, 299) == 0);
      data_i  = 16'($urandom);
      blank_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      dp_i    = 4'($urandom);
      lz_i    = 1'($urandom);
      // Small nibbles so leading-zero suppression actually triggers.
      if ($urandom_range(0, 2) == 0) data_i = data_i >> (4 * $urandom_range(1, 3));
      load_i  = ($urandom_range(0, 9) == 0);
    end
    reset  = 1'b0;
    load_i = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    load_i  = 1'b0;
    data_i  = '0;
    blank_i = '0;
    dp_i    = '0;
    lz_i    = 1'b0;
    test_reset();
    test_frame_updates();
    test_blank_dp();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
